perip_responder: RTL

//  Responder end of the core's data-side peripheral port (perip_addr/wen/mask/wdata/rdata).

---
 rtl/perip_responder_pkg.sv | 67 ++++++
 rtl/perip_responder_dram_bank.sv | 27 ++
 rtl/perip_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/perip_responder_pkg.sv
// Shared constants and helpers for the data-side peripheral responder.
// Contents: region base addresses, access-size encodings, counter command
// words, the region and timer-state enums, and byte-lane helper functions.
package perip_responder_pkg;

  localparam logic [31:0] DRAM_BASE = 32'h8010_0000;
  localparam logic [31:0] SW_ADDR   = 32'h8020_0000;
  localparam logic [31:0] SEG_ADDR  = 32'h8020_0020;
  localparam logic [31:0] LED_ADDR  = 32'h8020_0040;
  localparam logic [31:0] CNT_ADDR  = 32'h8020_0050;

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b10;

  localparam logic [31:0] CNT_CMD_START = 32'h8000_0000;
  localparam logic [31:0] CNT_CMD_STOP  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_DRAM,
    RGN_SW,
    RGN_SEG,
    RGN_LED,
    RGN_CNT
  } region_e;

  typedef enum logic {
    TMR_IDLE,
    TMR_RUN
  } tmr_state_e;

  // Reserved size code 11 behaves as a word access.
  function automatic logic misaligned(input logic [1:0] mask, input logic [1:0] lo);
    case (mask)
      MASK_B:  misaligned = 1'b0;
      MASK_H:  misaligned = lo[0];
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] mask, input logic [1:0] lo);
    case (mask)
      MASK_B:  lane_en = 4'b0001 << lo;
      MASK_H:  lane_en = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  endfunction

  // Replicating the LSB-aligned data puts it in whichever lanes are enabled.
  function automatic logic [31:0] lane_data(input logic [1:0] mask, input logic [31:0] d);
    case (mask)
      MASK_B:  lane_data = {4{d[7:0]}};
      MASK_H:  lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [3:0] be,
                                             input logic [31:0] wd);
    lane_merge = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) lane_merge[8*i +: 8] = wd[8*i +: 8];
    end
  endfunction

endpackage

// File: rtl/perip_responder_dram_bank.sv
// Byte-laned on-chip data RAM: four 8-bit lanes of 2^AW entries each.
// Ports: clk_i clock; addr_i word address; we_i per-lane write enable;
// wdata_i lane-positioned write data; rdata_o registered read word.
// Read is read-first: a write cycle returns the word as it was before the write.
module perip_responder_dram_bank #(
  parameter int unsigned AW = 16
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem_q [2**AW];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we_i[l]) mem_q[addr_i] <= wdata_i[8*l +: 8];
      rd_q <= mem_q[addr_i];
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/perip_responder.sv
// Responder for the core's data-side peripheral port. Decodes each access
// into byte-laned DRAM or the LED / 7-seg / switch / millisecond-counter
// registers and returns the full aligned word one cycle later.
// Ports: clk, rst (sync, active high); perip_addr/wen/mask/wdata request;
// perip_rdata registered read word; sw board switches (async);
// led, seg register outputs; bus_err sticky error flag.
// Build option: define PERIP_TIMER_EN to include the CNT counter; without
// it the CNT address decodes as unmapped.
module perip_responder
  import perip_responder_pkg::*;
#(
  parameter int unsigned DRAM_AW    = 16,
  parameter int unsigned SW_W       = 32,
  parameter int unsigned CLK_PER_MS = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     perip_addr,
  input  logic            perip_wen,
  input  logic [1:0]      perip_mask,
  input  logic [31:0]     perip_wdata,
  output logic [31:0]     perip_rdata,
  input  logic [SW_W-1:0] sw,
  output logic [31:0]     led,
  output logic [31:0]     seg,
  output logic            bus_err
);

  localparam logic [31:0] DRAM_BYTES = 32'd4 << DRAM_AW;

  region_e         rgn, rgn_q;
  logic [31:0]     dram_off;
  logic            misal, wr_ok, err_set;
  logic [3:0]      be, dram_we;
  logic [31:0]     wd, dram_rdata, cnt_val;
  logic [31:0]     led_q, led_d, seg_q, seg_d, io_rdata_q, io_rdata_d;
  logic            bus_err_q, bus_err_d;
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;

  // Addresses below the base wrap to large offsets and fall outside the window.
  assign dram_off = perip_addr - DRAM_BASE;

  always_comb begin
    rgn = RGN_NONE;
    if (dram_off < DRAM_BYTES)                   rgn = RGN_DRAM;
    else if (perip_addr[31:2] == SW_ADDR[31:2])  rgn = RGN_SW;
    else if (perip_addr[31:2] == SEG_ADDR[31:2]) rgn = RGN_SEG;
    else if (perip_addr[31:2] == LED_ADDR[31:2]) rgn = RGN_LED;
`ifdef PERIP_TIMER_EN
    else if (perip_addr[31:2] == CNT_ADDR[31:2]) rgn = RGN_CNT;
`endif
  end

  assign misal   = misaligned(perip_mask, perip_addr[1:0]);
  assign wr_ok   = perip_wen && !misal;
  assign be      = lane_en(perip_mask, perip_addr[1:0]);
  assign wd      = lane_data(perip_mask, perip_wdata);
  assign dram_we = (wr_ok && !rst && rgn == RGN_DRAM) ? be : 4'b0000;
  assign err_set = misal || (perip_wen && (rgn == RGN_NONE || rgn == RGN_SW));

  perip_responder_dram_bank #(
    .AW(DRAM_AW)
  ) u_dram (
    .clk_i  (clk),
    .addr_i (dram_off[DRAM_AW+1:2]),
    .we_i   (dram_we),
    .wdata_i(wd),
    .rdata_o(dram_rdata)
  );

  always_comb begin
    led_d      = led_q;
    seg_d      = seg_q;
    bus_err_d  = bus_err_q | err_set;
    io_rdata_d = 32'd0;
    if (wr_ok && rgn == RGN_LED) led_d = lane_merge(led_q, be, wd);
    if (wr_ok && rgn == RGN_SEG) seg_d = lane_merge(seg_q, be, wd);
    case (rgn)
      RGN_SW:  io_rdata_d = 32'(sw_sync_q);
      RGN_SEG: io_rdata_d = seg_q;
      RGN_LED: io_rdata_d = led_q;
      RGN_CNT: io_rdata_d = cnt_val;
      default: io_rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= 32'd0;
      seg_q      <= 32'd0;
      bus_err_q  <= 1'b0;
      io_rdata_q <= 32'd0;
      rgn_q      <= RGN_NONE;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      led_q      <= led_d;
      seg_q      <= seg_d;
      bus_err_q  <= bus_err_d;
      io_rdata_q <= io_rdata_d;
      rgn_q      <= rgn;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Both sources are registered; the mux is steered by last cycle's region.
  assign perip_rdata = (rgn_q == RGN_DRAM) ? dram_rdata : io_rdata_q;
  assign led         = led_q;
  assign seg         = seg_q;
  assign bus_err     = bus_err_q;

`ifdef PERIP_TIMER_EN
  // state    | meaning
  // TMR_IDLE | counter frozen, prescaler held
  // TMR_RUN  | prescaler advancing, cnt increments at prescaler terminal count
  localparam int unsigned PRESC_W = $clog2(CLK_PER_MS + 1);

  tmr_state_e         tmr_q, tmr_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               cnt_wr;

  assign cnt_wr = wr_ok && rgn == RGN_CNT;

  // A command write takes priority over the tick in the same cycle.
  always_comb begin
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    if (cnt_wr && perip_wdata == CNT_CMD_START) begin
      tmr_d   = TMR_RUN;
      cnt_d   = 32'd0;
      presc_d = '0;
    end else if (cnt_wr && perip_wdata == CNT_CMD_STOP) begin
      tmr_d = TMR_IDLE;
    end else if (tmr_q == TMR_RUN) begin
      if (presc_q == PRESC_W'(CLK_PER_MS - 1)) begin
        presc_d = '0;
        cnt_d   = cnt_q + 32'd1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q   <= TMR_IDLE;
      cnt_q   <= 32'd0;
      presc_q <= '0;
    end else begin
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
    end
  end

  assign cnt_val = cnt_q;
`else
  logic unused_timer_cfg;
  assign unused_timer_cfg = (CLK_PER_MS == 32'd0);
  assign cnt_val = 32'd0;
`endif

endmodule
